digital_clock_counter: RTL and testbench
========================================

DIGITAL_CLOCK_COUNTER -- requirements
Module: digital_clock_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, giving the input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_DIV, default CLK_HZ, giving clock cycles per one-second tick; it SHALL be at least 4 and even.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-005 SHALL have port run_en, input, 1 bit: enables timekeeping in run mode.
REQ-006 SHALL have port sel, input, 2 bits: mode select; 00 is run, 01 sets hours, 10 sets minutes, 11 sets seconds.
REQ-007 SHALL have port inc, input, 1 bit: increment request, synchronous level from an external debouncer.
REQ-008 SHALL have ports sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, each output, 8 bits: BCD digits zero-extended to 8 bits, for the downstream 7-segment decoders.
REQ-009 SHALL have port tick, output, 1 bit: one-cycle pulse on each second advance.
REQ-010 SHALL have port blink, output, 1 bit: 2 Hz square wave, high for the first half of each half-second.

Function
REQ-011 The prescaler SHALL count 0..TICK_DIV-1 while sel==00 and run_en==1, and SHALL hold its value while run_en==0.
REQ-012 tick SHALL assert for exactly one cycle, registered, in the cycle after the prescaler wraps from TICK_DIV-1 to 0.
REQ-013 Time SHALL advance by one second in the same cycle tick asserts, with a latency of 1 cycle from the prescaler wrap.
REQ-014 The seconds and minutes counters SHALL count 00..59 in BCD: the lo digit wraps 9->0 and increments hi, and 59->00 carries into the next field.
REQ-015 The hours counter SHALL count 00..23 in BCD, and 23:59:59 SHALL advance to 00:00:00 in a single tick.
REQ-016 Digit outputs SHALL never hold a value above 9, and the hi digits SHALL never exceed 5 (sec/min) or 2 (hr).
REQ-017 While sel!=00, the prescaler SHALL be held at 0, tick SHALL be held at 0, and time SHALL not advance.
REQ-018 A rising edge of inc, detected by a registered previous value, SHALL act 1 cycle after the edge; a held-high inc SHALL produce exactly one action.
REQ-019 With sel==01, an inc edge SHALL increment hours modulo 24 (23->00) without changing minutes or seconds.
REQ-020 With sel==10, an inc edge SHALL increment minutes modulo 60 (59->00) with no carry into hours.
REQ-021 With sel==11, an inc edge SHALL clear the seconds field to 00.
REQ-022 With sel==00, inc SHALL be ignored.
REQ-023 A change of sel from non-00 to 00 SHALL start the prescaler from 0, so the first tick follows TICK_DIV cycles later.
REQ-024 A change of sel between set modes in the same cycle as an inc edge SHALL apply the edge to the field selected by the new sel value.
REQ-025 blink SHALL be derived from a free-running counter independent of sel and run_en, with period CLK_HZ/2 cycles.

Reset
REQ-026 While rst_n==0, all digit outputs SHALL be 8'd0 (time 00:00:00), and tick, blink, the prescaler, the blink counter and the inc edge register SHALL all be 0.
REQ-027 An assertion of rst_n mid-operation, including in set mode or mid-carry, SHALL clear state immediately without waiting for a clock edge.
REQ-028 After rst_n deasserts with sel==00 and run_en==1, the first tick SHALL occur TICK_DIV cycles after the first active clock edge.

Structure
REQ-029 A shared header SHALL hold the sel encodings (SEL_RUN, SEL_HR, SEL_MIN, SEL_SEC) and the field limits (SEC_MAX 59, MIN_MAX 59, HR_MAX 23).
REQ-030 A sub-module bcd_mod_counter SHALL implement a two-digit BCD counter with parameter MOD (60 or 24), inputs en and clr, and outputs lo, hi and carry.
REQ-031 bcd_mod_counter SHALL be instantiated three times; carry SHALL be combinational and assert only when en==1 and the count is MOD-1.

Verification
REQ-032 The bench SHALL cover: TICK_DIV=4, reset released, run 60 ticks -> tick pulses every 4 cycles; sec reads 00 then min_lo=1.
REQ-033 The bench SHALL cover: time preloaded to 23:59:59 via set modes, then run one tick -> outputs 00:00:00 in one cycle, all digits 8'd0.
REQ-034 The bench SHALL cover: sel=10, minutes at 59, inc pulse -> minutes 00 with hours unchanged; inc held high 10 cycles -> exactly one increment.
REQ-035 The bench SHALL cover: run_en dropped for 7 cycles mid-count -> prescaler frozen; tick resumes after the remaining cycles, and seconds do not skip.
REQ-036 The bench SHALL cover: rst_n pulled low asynchronously between clock edges at 12:34:56 -> outputs 0 before the next edge.
REQ-037 The bench SHALL cover: sel=11 with seconds at 37, inc pulse -> seconds 00; switching to sel=00 -> first tick after exactly TICK_DIV cycles.

Source files
------------

// File: rtl/digital_clock_counter_pkg.sv
// -----------------------------------------------------------------------------
// digital_clock_counter_pkg
//   Shared definitions for the 24-hour BCD digital clock:
//     - sel_e      : mode-select encodings driven on the top-level sel port
//     - *_MAX      : last legal value of each time field
//     - digit_out  : zero-extends a BCD digit for the 7-segment decoder ports
// -----------------------------------------------------------------------------
package digital_clock_counter_pkg;

  // Mode select: run, or which field an inc edge modifies.
  typedef enum logic [1:0] {
    SEL_RUN = 2'b00,
    SEL_HR  = 2'b01,
    SEL_MIN = 2'b10,
    SEL_SEC = 2'b11
  } sel_e;

  // Field limits; each field counts 0..*_MAX.
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // Downstream decoders take 8-bit digits; upper nibble is always zero.
  function automatic logic [7:0] digit_out(input logic [3:0] digit);
    return {4'd0, digit};
  endfunction

endpackage : digital_clock_counter_pkg

// File: rtl/digital_clock_counter_bcd_mod_counter.sv
// -----------------------------------------------------------------------------
// bcd_mod_counter
//   Two-digit BCD counter that counts 00..MOD-1 and wraps to 00.
//   Use a modulus of 60 for seconds/minutes or 24 for hours.
//
// Ports
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset, clears the count to 00
//   en     in   advance the count by one on this clock edge
//   clr    in   force the count to 00 (wins over en)
//   lo     out  units BCD digit
//   hi     out  tens BCD digit
//   carry  out  combinational: en is high and the count is MOD-1, so the
//               next field up must advance on this same edge
// -----------------------------------------------------------------------------
module bcd_mod_counter #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] lo,
  output logic [3:0] hi,
  output logic       carry
);

  localparam logic [3:0] LO_LAST = 4'((MOD - 1) % 10);
  localparam logic [3:0] HI_LAST = 4'((MOD - 1) / 10);

  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic       at_last;

  assign at_last = (lo_q == LO_LAST) && (hi_q == HI_LAST);
  assign carry   = en && at_last;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // a variable unassigned would infer a latch.
    lo_d = lo_q;
    hi_d = hi_q;
    if (clr) begin
      lo_d = 4'd0;
      hi_d = 4'd0;
    end else if (en) begin
      if (at_last) begin
        lo_d = 4'd0;
        hi_d = 4'd0;
      end else if (lo_q == 4'd9) begin
        lo_d = 4'd0;
        hi_d = hi_q + 4'd1;
      end else begin
        lo_d = lo_q + 4'd1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q <= 4'd0;
      hi_q <= 4'd0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
    end
  end

  assign lo = lo_q;
  assign hi = hi_q;

endmodule : bcd_mod_counter

// File: rtl/digital_clock_counter.sv
// -----------------------------------------------------------------------------
// digital_clock_counter
//   24-hour HH:MM:SS clock with BCD digit outputs, a one-second prescaler,
//   a set mode that edits one field per inc rising edge, and a 2 Hz blink.
//
// Parameters
//   CLK_HZ    input clock frequency in Hz (blink period is CLK_HZ/2 cycles)
//   TICK_DIV  clock cycles per second tick (>= 4, even)
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   run_en         in   timekeeping enable while sel selects run
//   sel[1:0]       in   00 run, 01 set hours, 10 set minutes, 11 clear seconds
//   inc            in   debounced increment level; its rising edge acts once
//   sec_lo..hr_hi  out  BCD digits, zero-extended to 8 bits
//   tick           out  registered one-cycle pulse on each second advance
//   blink          out  2 Hz square wave, free-running
// -----------------------------------------------------------------------------
module digital_clock_counter
  import digital_clock_counter_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int TICK_DIV = CLK_HZ
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic [1:0] sel,
  input  logic       inc,
  output logic [7:0] sec_lo,
  output logic [7:0] sec_hi,
  output logic [7:0] min_lo,
  output logic [7:0] min_hi,
  output logic [7:0] hr_lo,
  output logic [7:0] hr_hi,
  output logic       tick,
  output logic       blink
);

  // ---------------------------------------------------------------------------
  // Widths and terminal counts
  // ---------------------------------------------------------------------------
  localparam int PW           = $clog2(TICK_DIV);
  localparam int BLINK_PERIOD = CLK_HZ / 2;
  localparam int BW           = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_HIGH = BW'(BLINK_PERIOD / 2);

  // ---------------------------------------------------------------------------
  // Mode decode and inc edge detect
  // ---------------------------------------------------------------------------
  sel_e mode;
  logic run_mode;
  logic inc_q;
  logic inc_edge;

  assign mode     = sel_e'(sel);
  assign run_mode = (mode == SEL_RUN);
  // inc_q holds last cycle's inc, so a held-high level yields one edge only.
  assign inc_edge = inc && !inc_q;

  // ---------------------------------------------------------------------------
  // One-second prescaler
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic          wrap;
  logic          tick_q;

  // The wrap edge is the edge on which the seconds field advances and tick
  // is loaded, so both become visible in the same cycle.
  assign wrap = run_mode && run_en && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (!run_mode) begin
      // Held at zero in set modes so returning to run restarts a full second.
      presc_d = '0;
    end else if (run_en) begin
      presc_d = wrap ? '0 : presc_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Time fields
  // ---------------------------------------------------------------------------
  logic       sec_en, sec_clr, sec_carry;
  logic       min_en, min_carry;
  logic       hr_en, hr_carry;
  logic [3:0] sec_lo_w, sec_hi_w;
  logic [3:0] min_lo_w, min_hi_w;
  logic [3:0] hr_lo_w,  hr_hi_w;

  assign sec_en  = wrap;
  assign sec_clr = inc_edge && (mode == SEL_SEC);

  // Carries only ripple in run mode; in set-minutes mode a 59->00 edit must
  // not touch the hours field.
  assign min_en = (run_mode && sec_carry) || (inc_edge && (mode == SEL_MIN));
  assign hr_en  = (run_mode && min_carry) || (inc_edge && (mode == SEL_HR));

  bcd_mod_counter #(.MOD(SEC_MAX + 1)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .clr   (sec_clr),
    .lo    (sec_lo_w),
    .hi    (sec_hi_w),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MOD(MIN_MAX + 1)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_en),
    .clr   (1'b0),
    .lo    (min_lo_w),
    .hi    (min_hi_w),
    .carry (min_carry)
  );

  // Hours carry is the day rollover; nothing above it consumes it.
  bcd_mod_counter #(.MOD(HR_MAX + 1)) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hr_en),
    .clr   (1'b0),
    .lo    (hr_lo_w),
    .hi    (hr_hi_w),
    .carry (hr_carry)
  );

  // ---------------------------------------------------------------------------
  // Blink: free-running, independent of sel and run_en
  // ---------------------------------------------------------------------------
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  always_comb begin
    blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
    // Registered from the current count: high while the counter is in the
    // first half of its period, and low out of reset.
    blink_d     = (blink_cnt_q < BLINK_HIGH);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      tick_q      <= 1'b0;
      inc_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= wrap;
      inc_q       <= inc;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sec_lo = digit_out(sec_lo_w);
  assign sec_hi = digit_out(sec_hi_w);
  assign min_lo = digit_out(min_lo_w);
  assign min_hi = digit_out(min_hi_w);
  assign hr_lo  = digit_out(hr_lo_w);
  assign hr_hi  = digit_out(hr_hi_w);
  assign tick   = tick_q;
  assign blink  = blink_q;

endmodule : digital_clock_counter

// File: tb/tb_digital_clock_counter.sv
// -----------------------------------------------------------------------------
// tb_digital_clock_counter
//   Directed stimulus with a time-of-day model kept as a plain seconds-of-day
//   integer. Every falling edge compares the six digits and tick against the
//   model, and blink against its required period and duty. Directed checks
//   pin literal values at the interesting points.
// -----------------------------------------------------------------------------
module tb_digital_clock_counter;
  import digital_clock_counter_pkg::*;

  localparam int CLK_HZ   = 16;
  localparam int TICK_DIV = 4;
  localparam int BLINK_P  = CLK_HZ / 2;
  localparam int DAY      = 24 * 3600;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run_en;
  logic [1:0] sel;
  logic       inc;
  logic [7:0] sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi;
  logic       tick;
  logic       blink;

  digital_clock_counter #(
    .CLK_HZ   (CLK_HZ),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run_en (run_en),
    .sel    (sel),
    .inc    (inc),
    .sec_lo (sec_lo),
    .sec_hi (sec_hi),
    .min_lo (min_lo),
    .min_hi (min_hi),
    .hr_lo  (hr_lo),
    .hr_hi  (hr_hi),
    .tick   (tick),
    .blink  (blink)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [47:0] dut_time;
  assign dut_time = {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo};

  // Expected digit vector for a given second of the day.
  function automatic logic [47:0] digits_of(input int s);
    int h, m, x;
    h = s / 3600;
    m = (s / 60) % 60;
    x = s % 60;
    return {8'(h / 10), 8'(h % 10), 8'(m / 10), 8'(m % 10),
            8'(x / 10), 8'(x % 10)};
  endfunction

  // ---------------------------------------------------------------------------
  // Model: seconds of day, elapsed run cycles in the current second
  // ---------------------------------------------------------------------------
  int m_secs;
  int m_cycles;
  int m_min;
  bit m_tick;
  bit m_inc_prev;
  bit m_rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_secs     = 0;
      m_cycles   = 0;
      m_tick     = 1'b0;
      m_inc_prev = 1'b0;
    end else begin
      m_rise     = inc && !m_inc_prev;
      m_inc_prev = inc;
      m_tick     = 1'b0;
      if (sel == SEL_RUN) begin
        if (run_en) begin
          m_cycles++;
          if (m_cycles == TICK_DIV) begin
            m_cycles = 0;
            m_tick   = 1'b1;
            m_secs   = (m_secs + 1) % DAY;
          end
        end
      end else begin
        m_cycles = 0;
        if (m_rise) begin
          case (sel)
            SEL_HR:  m_secs = (m_secs + 3600) % DAY;
            SEL_MIN: begin
              m_min  = (m_secs / 60) % 60;
              m_secs = m_secs + (((m_min + 1) % 60) - m_min) * 60;
            end
            default: m_secs = m_secs - (m_secs % 60);
          endcase
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------
  bit b_prev, b_seen;
  int b_since, b_high;

  always @(negedge clk) begin
    if (!rst_n) begin
      b_prev  = 1'b0;
      b_seen  = 1'b0;
      b_since = 0;
      b_high  = 0;
    end else begin
      check("time", 64'(dut_time), 64'(digits_of(m_secs)));
      check("tick", 64'(tick), 64'(m_tick));
      b_since++;
      if (blink && !b_prev) begin
        if (b_seen) check("blink_period", 64'(b_since), 64'(BLINK_P));
        b_seen  = 1'b1;
        b_since = 0;
        b_high  = 0;
      end
      if (blink) b_high++;
      if (!blink && b_prev && b_seen)
        check("blink_high_len", 64'(b_high), 64'(BLINK_P / 2));
      b_prev = blink;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_inc();
    inc = 1'b1;
    step(1);
    inc = 1'b0;
    step(1);
  endtask

  // Counts clock edges until tick is seen; a timeout counts as a failure.
  task automatic wait_tick(input int max_cyc, output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!tick && n < max_cyc);
    check("tick_seen", 64'(tick), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int n;

  initial begin
    rst_n  = 1'b0;
    run_en = 1'b1;
    sel    = SEL_RUN;
    inc    = 1'b0;

    #1;
    check("reset_time",  64'(dut_time), 64'h0);
    check("reset_tick",  64'(tick),     64'h0);
    check("reset_blink", 64'(blink),    64'h0);
    #19;
    check("reset_hold_time", 64'(dut_time), 64'h0);
    #2 rst_n = 1'b1;

    // Free run from reset: first tick on the TICK_DIV-th edge, then steady.
    wait_tick(10, n);
    check("first_tick_latency", 64'(n), 64'(TICK_DIV));
    check("first_tick_sec", 64'(sec_lo), 64'd1);
    repeat (59) begin
      wait_tick(10, n);
      check("tick_period", 64'(n), 64'(TICK_DIV));
    end
    check("min_rollover", 64'(dut_time), 48'h00_00_00_01_00_00);

    // Preload 23:59:00 through the set modes, then run to 23:59:59.
    sel = SEL_HR;
    repeat (23) pulse_inc();
    sel = SEL_MIN;
    repeat (58) pulse_inc();
    sel = SEL_SEC;
    pulse_inc();
    check("preload", 64'(dut_time), 48'h02_03_05_09_00_00);
    sel = SEL_RUN;
    repeat (59) wait_tick(10, n);
    check("at_2359_59", 64'(dut_time), 48'h02_03_05_09_05_09);
    wait_tick(10, n);
    check("day_rollover", 64'(dut_time), 48'h0);
    check("day_rollover_tick", 64'(tick), 64'd1);

    // Minutes edited to 59, then one more edge wraps with no hour carry.
    sel = SEL_MIN;
    repeat (59) pulse_inc();
    check("min_at_59", 64'(dut_time), 48'h00_00_05_09_00_00);
    pulse_inc();
    check("min_wrap_no_carry", 64'(dut_time), 48'h0);
    inc = 1'b1;
    step(1);
    check("inc_latency", 64'(min_lo), 64'd1);
    step(9);
    inc = 1'b0;
    step(1);
    check("inc_held_once", 64'(dut_time), 48'h00_00_00_01_00_00);

    // Back to run: full second, then freeze mid-count for 7 cycles.
    sel = SEL_RUN;
    wait_tick(10, n);
    check("run_restart_latency", 64'(n), 64'(TICK_DIV));
    step(2);
    run_en = 1'b0;
    step(7);
    run_en = 1'b1;
    wait_tick(10, n);
    check("freeze_remaining", 64'(n), 64'd2);
    check("freeze_no_skip", 64'(dut_time), 48'h00_00_00_01_00_02);

    // Seconds at 37, cleared in set mode, then exactly one second to tick.
    repeat (35) wait_tick(10, n);
    check("sec_at_37", 64'(dut_time), 48'h00_00_00_01_03_07);
    sel = SEL_SEC;
    pulse_inc();
    check("sec_clear", 64'(dut_time), 48'h00_00_00_01_00_00);
    sel = SEL_RUN;
    wait_tick(10, n);
    check("set_to_run_latency", 64'(n), 64'(TICK_DIV));

    // inc is ignored in run mode.
    pulse_inc();
    check("run_inc_ignored", 64'(dut_time), 48'h00_00_00_01_00_01);

    // Switching sel with an inc edge in the same cycle edits the new field.
    sel = SEL_MIN;
    step(1);
    sel = SEL_HR;
    inc = 1'b1;
    step(1);
    inc = 1'b0;
    check("sel_switch_edge", 64'(dut_time), 48'h00_01_00_01_00_01);
    step(1);

    // Build 12:34:56, then assert reset between clock edges.
    repeat (11) pulse_inc();
    sel = SEL_MIN;
    repeat (33) pulse_inc();
    sel = SEL_SEC;
    pulse_inc();
    sel = SEL_RUN;
    repeat (56) wait_tick(10, n);
    check("at_12_34_56", 64'(dut_time), 48'h01_02_03_04_05_06);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_time", 64'(dut_time), 64'h0);
    check("async_reset_tick", 64'(tick), 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_tick(10, n);
    check("post_reset_latency", 64'(n), 64'(TICK_DIV));
    step(2 * BLINK_P);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_digital_clock_counter
